stopwatch_ctl: RTL and testbench
================================

Name: stopwatch_ctl

Overview:
Control sequencer for the stopwatch counter datapath. It debounces the run, clear/split and timepoint buttons and arbitrates their events against CPU commands written over Avalon. A run/stop/split/clear state machine then drives the counter enable, counter clear, display-hold and timepoint-capture strobes. It sits between the raw button pins plus the Avalon slave and the BCD counter/latch datapath.

Parameters:
DBN, 8, debounce length: consecutive stable synchronized samples needed to accept a level change (>=2)
DBW, 4, debounce counter width; must satisfy 2**DBW > DBN
ADW, 32, Avalon data width

Ports:
clk  in  1  system clock
rst  in  1  reset; synchronous, active-high
b_run  in  1  raw run/stop button, asynchronous
b_clr  in  1  raw clear/split button, asynchronous
b_tmp  in  1  raw timepoint button, asynchronous
cnt_ena  out  1  counter advance enable (level)
cnt_clr  out  1  counter clear strobe (1 cycle)
hld_load  out  1  display latch load strobe (1 cycle)
tmp_load  out  1  timepoint capture strobe (1 cycle)
s_run  out  1  run status indicator
s_hld  out  1  hold status indicator
avalon_write  in  1  command write
avalon_read  in  1  status read
avalon_writedata  in  ADW  command: bit0 run, bit1 clr, bit2 tmp, other bits ignored
avalon_readdata  out  ADW  status word
avalon_interrupt  out  1  timepoint interrupt
avalon_error  out  1  1-cycle pulse: command dropped

Behaviour:
- Per button: 2-flop synchronizer -> debounce counter. A change is accepted after DBN consecutive samples differ from the held level. The counter reset to 0 on any sample equal to the held level. Rising edge of the debounced level = one-cycle event. For a clean press, the event occurs DBN+2 cycles after the input rises. Releases generate no event.
- Command register: one entry (cmd_pend, cmd[2:0]), loaded on avalon_write whose bits[2:0] are nonzero. A write with bits[2:0]=0 is ignored.
- Arbitration per cycle: a button event wins. A pending command is serviced on the first cycle with no button event.
- Avalon write while cmd_pend=1 and the entry is not consumed that cycle -> write dropped, avalon_error pulses the next cycle.
- Event priority within one source: run > clr > tmp. Lower-priority simultaneous events are discarded.
- FSM states: IDLE (stopped, cleared), RUN, SPLIT (running, display held), STOP (stopped, not cleared).
- IDLE: run -> RUN. clr -> IDLE with cnt_clr. tmp ignored.
- RUN: run -> STOP. clr -> SPLIT with hld_load. tmp -> RUN with tmp_load.
- SPLIT: clr -> RUN (release). run -> STOP (release). tmp -> SPLIT with tmp_load.
- STOP: run -> RUN. clr -> IDLE with cnt_clr. tmp ignored.
- Outputs are registered; strobes assert the cycle after the event/command is serviced.
- Output levels: cnt_ena = s_run = (RUN|SPLIT); s_hld = SPLIT.
- avalon_readdata: registered, valid 1 cycle after avalon_read. Bits [1:0] state (IDLE=0, RUN=1, SPLIT=2, STOP=3), bit2 irq_flag, bit3 cmd_pend, rest 0.
- rst: FSM->IDLE. All outputs 0, debounce levels/counters 0, synchronizers 0, cmd_pend 0, irq_flag 0. Reset mid-debounce or mid-command discards all in-flight state.

Optional Feature:
STOPWATCH_CTL_IRQ_EN:
- Defined: each tmp_load sets irq_flag, and avalon_interrupt = irq_flag. An avalon_read clears irq_flag after the returned data samples it. If set and clear coincide, set wins.
- Undefined: irq_flag held 0, avalon_interrupt tied 0, readdata bit2 reads 0.

Test Plan:
- Reset, then b_run high 10 cycles (DBN=8) -> exactly one event. cnt_ena/s_run rise at cycle DBN+3 after press. State RUN.
- RUN, b_clr pulse -> hld_load 1 cycle, s_hld=1. Second b_clr -> s_hld=0, cnt_ena stays 1.
- b_run glitch high 5 cycles -> no event, state unchanged. Then b_run then b_clr presses from RUN -> STOP, then IDLE with one cnt_clr pulse.
- Avalon write 0x1 on the same cycle a b_clr event fires in RUN -> clr serviced first (SPLIT). Command serviced the next cycle -> STOP. A second write while pending -> avalon_error pulse.
- With STOPWATCH_CTL_IRQ_EN, RUN plus b_tmp -> tmp_load pulse, interrupt=1, read returns 0x5 and interrupt drops. Without the macro, the same read returns 0x1 and interrupt stays 0.
- Assert rst during SPLIT with a command pending -> next cycle all outputs 0, state IDLE, readdata 0 on the following read.

Source files
------------

// File: rtl/stopwatch_ctl.sv
// stopwatch_ctl -- control sequencer for the stopwatch counter datapath.
//
// Debounces the run, clear/split and timepoint buttons and arbitrates the
// resulting events against single-entry CPU commands written over Avalon.
// A run/stop/split/clear state machine drives the counter enable, the
// counter clear, display-hold and timepoint-capture strobes.
//
// Optional build macro: STOPWATCH_CTL_IRQ_EN
//   defined   - each tmp_load sets irq_flag; avalon_interrupt = irq_flag;
//               a status read clears it (a simultaneous set wins).
//   undefined - irq_flag is constant 0, interrupt tied low.
//
// Parameters:
//   DBN  consecutive stable samples needed to accept a level change (>= 2)
//   DBW  debounce counter width, 2**DBW must exceed DBN
//   ADW  Avalon data width (>= 4)
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   b_run/b_clr/b_tmp  raw asynchronous buttons
//   cnt_ena            counter advance enable (level)
//   cnt_clr            counter clear strobe (1 cycle)
//   hld_load           display latch load strobe (1 cycle)
//   tmp_load           timepoint capture strobe (1 cycle)
//   s_run, s_hld       run / hold status indicators
//   avalon_write       command write: writedata bit0 run, bit1 clr, bit2 tmp
//   avalon_read        status read, readdata valid one cycle later
//   avalon_readdata    [1:0] state, [2] irq_flag, [3] cmd_pend, rest 0
//   avalon_interrupt   timepoint interrupt
//   avalon_error       1-cycle pulse when a command write is dropped
module stopwatch_ctl #(
  parameter int DBN = 8,
  parameter int DBW = 4,
  parameter int ADW = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           b_run,
  input  logic           b_clr,
  input  logic           b_tmp,
  output logic           cnt_ena,
  output logic           cnt_clr,
  output logic           hld_load,
  output logic           tmp_load,
  output logic           s_run,
  output logic           s_hld,
  input  logic           avalon_write,
  input  logic           avalon_read,
  input  logic [ADW-1:0] avalon_writedata,
  output logic [ADW-1:0] avalon_readdata,
  output logic           avalon_interrupt,
  output logic           avalon_error
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_SPLIT = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  localparam logic [DBW-1:0] DB_LAST = DBW'(DBN - 1);

  // Event vectors are ordered {tmp, clr, run}.
  logic [2:0]           btn_raw;
  logic [2:0]           btn_p0;
  logic [2:0]           btn_p1;
  logic [2:0]           db_lvl;
  logic [2:0]           db_lvl_d;
  logic [2:0][DBW-1:0]  db_cnt;
  logic [2:0]           btn_ev;

  logic                 cmd_pend;
  logic [2:0]           cmd;
  logic                 any_btn;
  logic                 cmd_take;
  logic [2:0]           src_ev;
  logic                 ev_run;
  logic                 ev_clr;
  logic                 ev_tmp;
  logic                 wr_cmd;
  logic                 wr_load;
  logic                 wr_drop;

  state_t               state;
  state_t               state_nxt;
  logic                 clr_nxt;
  logic                 hld_nxt;
  logic                 tmp_nxt;
  logic                 irq_flag;
  logic                 unused_wd;

  assign btn_raw = {b_tmp, b_clr, b_run};

  // Stage p0/p1: two-flop synchronizer for the asynchronous buttons.
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_p0 <= 3'b000;
      btn_p1 <= 3'b000;
    end else begin
      btn_p0 <= btn_raw;
      btn_p1 <= btn_p0;
    end
  end

  // Debounce: the held level only flips after DBN consecutive synchronized
  // samples disagree with it; any agreeing sample restarts the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      db_lvl   <= 3'b000;
      db_lvl_d <= 3'b000;
      db_cnt   <= '0;
    end else begin
      db_lvl_d <= db_lvl;
      for (int i = 0; i < 3; i++) begin
        if (btn_p1[i] == db_lvl[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db_lvl[i] <= btn_p1[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DBW'(1);
        end
      end
    end
  end

  // Only presses are events; releases are absorbed here.
  assign btn_ev = db_lvl & ~db_lvl_d;

  // Button events always win the cycle; the pending command waits for the
  // first cycle without one.
  assign any_btn  = |btn_ev;
  assign cmd_take = cmd_pend & ~any_btn;
  assign src_ev   = any_btn ? btn_ev : (cmd_take ? cmd : 3'b000);

  // Within one source run beats clr beats tmp; losers are discarded.
  assign ev_run = src_ev[0];
  assign ev_clr = src_ev[1] & ~src_ev[0];
  assign ev_tmp = src_ev[2] & ~src_ev[1] & ~src_ev[0];

  // A write only needs the single entry to be free by the end of the cycle,
  // so a command consumed this cycle can be replaced immediately.
  assign wr_cmd  = avalon_write & (|avalon_writedata[2:0]);
  assign wr_load = wr_cmd & (~cmd_pend | cmd_take);
  assign wr_drop = wr_cmd & cmd_pend & ~cmd_take;

  assign unused_wd = ^avalon_writedata[ADW-1:3];

  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_pend     <= 1'b0;
      cmd          <= 3'b000;
      avalon_error <= 1'b0;
    end else begin
      avalon_error <= wr_drop;
      if (wr_load) begin
        cmd_pend <= 1'b1;
        cmd      <= avalon_writedata[2:0];
      end else if (cmd_take) begin
        cmd_pend <= 1'b0;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    clr_nxt   = 1'b0;
    hld_nxt   = 1'b0;
    tmp_nxt   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (ev_run) begin
          state_nxt = ST_RUN;
        end else if (ev_clr) begin
          clr_nxt = 1'b1;
        end
      end
      ST_RUN: begin
        if (ev_run) begin
          state_nxt = ST_STOP;
        end else if (ev_clr) begin
          state_nxt = ST_SPLIT;
          hld_nxt   = 1'b1;
        end else if (ev_tmp) begin
          tmp_nxt = 1'b1;
        end
      end
      ST_SPLIT: begin
        if (ev_run) begin
          state_nxt = ST_STOP;
        end else if (ev_clr) begin
          state_nxt = ST_RUN;
        end else if (ev_tmp) begin
          tmp_nxt = 1'b1;
        end
      end
      ST_STOP: begin
        if (ev_run) begin
          state_nxt = ST_RUN;
        end else if (ev_clr) begin
          state_nxt = ST_IDLE;
          clr_nxt   = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Stage p2: registered state and outputs, one cycle after service.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt_clr  <= 1'b0;
      hld_load <= 1'b0;
      tmp_load <= 1'b0;
      cnt_ena  <= 1'b0;
      s_run    <= 1'b0;
      s_hld    <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt_clr  <= clr_nxt;
      hld_load <= hld_nxt;
      tmp_load <= tmp_nxt;
      cnt_ena  <= (state_nxt == ST_RUN) || (state_nxt == ST_SPLIT);
      s_run    <= (state_nxt == ST_RUN) || (state_nxt == ST_SPLIT);
      s_hld    <= (state_nxt == ST_SPLIT);
    end
  end

`ifdef STOPWATCH_CTL_IRQ_EN
  // Set is tested first so a capture coinciding with a read is not lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_flag <= 1'b0;
    end else if (tmp_nxt) begin
      irq_flag <= 1'b1;
    end else if (avalon_read) begin
      irq_flag <= 1'b0;
    end
  end
`else
  assign irq_flag = 1'b0;
`endif

  assign avalon_interrupt = irq_flag;

  // Read data samples the pre-update flags, so the flag a read clears is
  // still reported by that read.
  always_ff @(posedge clk) begin
    if (rst) begin
      avalon_readdata <= '0;
    end else if (avalon_read) begin
      avalon_readdata <= {{(ADW-4){1'b0}}, cmd_pend, irq_flag, state};
    end
  end

endmodule

// File: tb/tb_stopwatch_ctl.sv
module tb_stopwatch_ctl;
  localparam int DBN = 8;
  localparam int DBW = 4;
  localparam int ADW = 32;
`ifdef STOPWATCH_CTL_IRQ_EN
  localparam logic IRQ = 1'b1;
`else
  localparam logic IRQ = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, b_run, b_clr, b_tmp;
  logic cnt_ena, cnt_clr, hld_load, tmp_load, s_run, s_hld;
  logic avalon_write, avalon_read;
  logic [ADW-1:0] avalon_writedata, avalon_readdata;
  logic avalon_interrupt, avalon_error;

  stopwatch_ctl #(.DBN(DBN), .DBW(DBW), .ADW(ADW)) dut (
    .clk(clk), .rst(rst), .b_run(b_run), .b_clr(b_clr), .b_tmp(b_tmp),
    .cnt_ena(cnt_ena), .cnt_clr(cnt_clr), .hld_load(hld_load),
    .tmp_load(tmp_load), .s_run(s_run), .s_hld(s_hld),
    .avalon_write(avalon_write), .avalon_read(avalon_read),
    .avalon_writedata(avalon_writedata), .avalon_readdata(avalon_readdata),
    .avalon_interrupt(avalon_interrupt), .avalon_error(avalon_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t stb_q[$];
  exp_t rd_q[$];
  exp_t e;
  logic rd_d = 1'b0;
  int   n_chk = 0;
  int   n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, want);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_stb(input string tag, input logic [31:0] v);
    stb_q.push_back('{tag, v});
  endtask

  task automatic do_read(input string tag, input logic [31:0] v);
    rd_q.push_back('{tag, v});
    avalon_read = 1'b1;
    tick(1);
    avalon_read = 1'b0;
    tick(1);
  endtask

  // which: 0 run, 1 clr, 2 tmp
  task automatic press(input int which);
    case (which)
      0: b_run = 1'b1;
      1: b_clr = 1'b1;
      default: b_tmp = 1'b1;
    endcase
    tick(DBN + 4);
    b_run = 1'b0;
    b_clr = 1'b0;
    b_tmp = 1'b0;
    tick(DBN + 6);
  endtask

  always @(posedge clk) rd_d <= avalon_read;

  // Strobe records are {cnt_clr, hld_load, tmp_load, s_run, s_hld}.
  always @(negedge clk) begin
    if (cnt_clr | hld_load | tmp_load) begin
      if (stb_q.size() == 0) begin
        chk("strobe_unexpected", 32'({cnt_clr, hld_load, tmp_load}), 32'h0);
      end else begin
        e = stb_q.pop_front();
        chk(e.tag, 32'({cnt_clr, hld_load, tmp_load, s_run, s_hld}), e.val);
      end
    end
    if (rd_d) begin
      if (rd_q.size() == 0) begin
        chk("read_unexpected", avalon_readdata, 32'hFFFF_FFFF);
      end else begin
        e = rd_q.pop_front();
        chk(e.tag, avalon_readdata, e.val);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    b_run = 1'b0; b_clr = 1'b0; b_tmp = 1'b0;
    avalon_write = 1'b0; avalon_read = 1'b0; avalon_writedata = '0;
    tick(3);
    chk("reset_outs", 32'({cnt_ena, cnt_clr, hld_load, tmp_load, s_run, s_hld,
                          avalon_interrupt, avalon_error}), 32'h0);
    chk("reset_rdata", avalon_readdata, 32'h0);
    rst = 1'b0;
    tick(2);
    do_read("rd_idle", 32'h0);

    // Run press: enable rises DBN+3 cycles after the press.
    b_run = 1'b1;
    tick(DBN + 2);
    chk("ena_early", 32'(cnt_ena), 32'h0);
    tick(1);
    chk("ena_rise", 32'({cnt_ena, s_run, s_hld}), 32'b110);
    tick(1);
    b_run = 1'b0;
    tick(DBN + 6);
    do_read("rd_run", 32'h1);

    // Split and release.
    push_stb("split_hld", 32'h0B);
    press(1);
    chk("split_lvl", 32'({cnt_ena, s_run, s_hld}), 32'b111);
    press(1);
    chk("unsplit_lvl", 32'({cnt_ena, s_run, s_hld}), 32'b110);

    // Short glitch is rejected.
    b_run = 1'b1;
    tick(5);
    b_run = 1'b0;
    tick(DBN + 6);
    chk("glitch_lvl", 32'({cnt_ena, s_run, s_hld}), 32'b110);
    do_read("rd_glitch", 32'h1);

    // Stop then clear.
    press(0);
    chk("stop_lvl", 32'({cnt_ena, s_run, s_hld}), 32'b000);
    do_read("rd_stop", 32'h3);
    push_stb("clear", 32'h10);
    press(1);
    chk("idle_lvl", 32'({cnt_ena, s_run, s_hld}), 32'b000);
    do_read("rd_idle2", 32'h0);

    press(0);
    chk("run_again", 32'({cnt_ena, s_run, s_hld}), 32'b110);

    // Command written the same cycle as a clr event: clr first, then run.
    push_stb("arb_hld", 32'h0B);
    b_clr = 1'b1;
    tick(DBN + 2);
    avalon_write = 1'b1;
    avalon_writedata = 32'hA5A5_A5A1;
    tick(1);
    avalon_write = 1'b0;
    avalon_writedata = '0;
    chk("arb_split", 32'({cnt_ena, s_run, s_hld}), 32'b111);
    tick(1);
    chk("arb_stop", 32'({cnt_ena, s_run, s_hld}), 32'b000);
    tick(2);
    b_clr = 1'b0;
    tick(DBN + 6);
    do_read("rd_arb", 32'h3);

    // Write with zero command bits is ignored.
    avalon_write = 1'b1;
    avalon_writedata = 32'h8;
    tick(1);
    avalon_write = 1'b0;
    avalon_writedata = '0;
    tick(2);
    chk("zero_write", 32'({cnt_ena, avalon_error}), 32'h0);
    do_read("rd_zero", 32'h3);

    // Dropped write: entry held pending by a tmp event the next cycle.
    push_stb("err_tmp", 32'h06);
    push_stb("err_hld", 32'h0B);
    b_run = 1'b1;
    tick(1);
    b_tmp = 1'b1;
    tick(DBN + 1);
    avalon_write = 1'b1;
    avalon_writedata = 32'h2;
    tick(1);
    avalon_writedata = 32'h4;
    tick(1);
    avalon_write = 1'b0;
    avalon_writedata = '0;
    chk("err_pulse", 32'(avalon_error), 32'h1);
    tick(1);
    chk("err_once", 32'(avalon_error), 32'h0);
    chk("err_irq", 32'(avalon_interrupt), 32'(IRQ));
    tick(2);
    b_run = 1'b0;
    b_tmp = 1'b0;
    tick(DBN + 6);
    do_read("rd_split_irq", IRQ ? 32'h6 : 32'h2);
    chk("irq_cleared", 32'(avalon_interrupt), 32'h0);

    // Timepoint in RUN.
    press(1);
    chk("back_run", 32'({cnt_ena, s_run, s_hld}), 32'b110);
    push_stb("tmp_run", 32'h06);
    press(2);
    chk("tmp_irq", 32'(avalon_interrupt), 32'(IRQ));
    do_read("rd_tmp", IRQ ? 32'h5 : 32'h1);
    chk("irq_drop", 32'(avalon_interrupt), 32'h0);

    // Reset during SPLIT with a command pending.
    push_stb("rst_hld", 32'h0B);
    press(1);
    chk("rst_split", 32'({cnt_ena, s_run, s_hld}), 32'b111);
    avalon_write = 1'b1;
    avalon_writedata = 32'h1;
    tick(1);
    avalon_write = 1'b0;
    avalon_writedata = '0;
    rst = 1'b1;
    tick(1);
    chk("rst_outs", 32'({cnt_ena, cnt_clr, hld_load, tmp_load, s_run, s_hld,
                        avalon_interrupt, avalon_error}), 32'h0);
    chk("rst_rdata", avalon_readdata, 32'h0);
    rst = 1'b0;
    tick(DBN + 4);
    chk("rst_no_cmd", 32'({cnt_ena, s_run, s_hld}), 32'b000);
    do_read("rd_rst", 32'h0);

    tick(2);
    chk("sb_stb_empty", 32'(stb_q.size()), 32'h0);
    chk("sb_rd_empty", 32'(rd_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
